ysyx_22040931_ifu_fetch: RTL and testbench
==========================================

# ysyx_22040931_ifu_fetch

Instruction-fetch responder on the consumer side of the PC stage's valid/ready handshake. It accepts a PC from the PC generator and issues a single-outstanding read on the instruction-memory request/ack port. It buffers returned instructions in a 2-entry FIFO and presents {pc, inst} to the ID stage under a second valid/ready handshake. Flush drops buffered entries and discards any in-flight response.

## Interface
- PC_W, 64, PC / address width
- INST_W, 32, instruction width
- clock  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard buffered and in-flight fetches (branch mispredict / redirect)
- pc_valid  in  1  PC stage offers a PC
- if_pc  in  PC_W  offered PC
- if_ready  out  1  PC accepted this cycle when pc_valid & if_ready
- imem_req  out  1  read request, held until ack
- imem_addr  out  PC_W  request address, stable while imem_req=1
- imem_ack  in  1  read complete; valid only while imem_req=1
- imem_rdata  in  INST_W  instruction, valid with imem_ack
- id_valid  out  1  head entry valid for ID
- id_ready  in  1  ID consumes head
- id_pc  out  PC_W  head PC
- id_inst  out  INST_W  head instruction
- id_exc  out  1  head carries misaligned-fetch exception

## Operation
- States: IDLE (no request outstanding), WAIT (imem_req=1, result kept), DRAIN (imem_req=1, result discarded).
- occ = count + (state==WAIT); pop = id_valid & id_ready.
- if_ready = ~flush & (state==IDLE | (state==WAIT & imem_ack)) & (occ - pop < 2). This is a combinational path from id_ready to if_ready.
- accept = pc_valid & if_ready: imem_addr <= if_pc, state -> WAIT.
- In WAIT with imem_ack and ~flush: push {imem_addr, imem_rdata, 0}. State becomes WAIT if accept occurs in the same cycle, otherwise IDLE.
- imem_req = (state==WAIT | state==DRAIN). It is registered state, not combinational from pc_valid.
- FIFO: 2 entries, in order, with simultaneous push and pop allowed. id_valid = (count!=0) & ~flush. The id_* outputs show the head entry.
- Flush (priority over everything):
  - count <= 0; pop and push are ignored.
  - WAIT without ack -> DRAIN; WAIT with ack -> IDLE, data dropped; DRAIN stays DRAIN.
- DRAIN + imem_ack -> IDLE, data dropped. if_ready=0 throughout DRAIN.
- Reset mid-request: state -> IDLE and imem_req drops next cycle. The memory side is reset together with this block.

## Timing
- Reset values: state IDLE, count 0, imem_req 0, imem_addr 0, id_valid 0, id_pc 0, id_inst 0, id_exc 0. if_ready is 1 once reset deasserts.
- Accept in cycle N -> imem_req=1 from N+1.
- imem_ack is allowed in the first req cycle. Ack in cycle M -> id_valid=1 in M+1.
- Minimum accept-to-id_valid latency is 2 cycles.
- Sustained throughput is 1 instruction/cycle with zero-wait memory and id_ready=1.
- At most one request is outstanding; a new request is issued only in the cycle after an ack.
- imem_addr changes only on accept.

## Configuration
- `YSYX_22040931_INST_MISALIGN_CHECK_EN` defined:
  - An accepted PC with if_pc[1:0]!=0 issues no memory request. It pushes {if_pc, 32'h00000013, 1} directly at the end of the accept cycle, and state stays IDLE.
  - Misaligned PCs are accepted only from IDLE; the WAIT & imem_ack path of if_ready additionally requires if_pc[1:0]==0.
- Undefined: every PC is issued to memory as-is, and id_exc is tied to 0.

## Test plan
- Reset then pc_valid=1, if_pc=0x80000000, ack on first req cycle, id_ready=1 -> imem_addr=0x80000000 at N+1, id_valid=1 with id_pc=0x80000000, id_inst=imem_rdata at N+2.
- Back-to-back PCs 0x80000000/04/08, zero-wait ack, id_ready=1 -> one id_valid per cycle in order, if_ready stays 1.
- id_ready=0 while streaming -> FIFO fills to 2 and if_ready=0. Raising id_ready pops 0x80000000 first, with no loss or duplication.
- Ack latency 3, flush asserted in second req cycle -> FIFO empties, state DRAIN, imem_req held with same addr, ack data dropped, if_ready=1 the cycle after ack.
- Flush coincident with ack and id_ready -> no push, no pop visible, id_valid=0 next cycle, state IDLE.
- With `YSYX_22040931_INST_MISALIGN_CHECK_EN`: if_pc=0x80000002 -> imem_req stays 0; next cycle id_valid=1, id_inst=0x00000013, id_exc=1.

Source files
------------

// File: rtl/ysyx_22040931_ifu_fetch_if.sv
// Fetch-unit bus: PC-stage handshake, instruction-memory request/ack port,
// ID-stage handshake and flush. master = fetch unit, slave = its surroundings.
interface ysyx_22040931_ifu_fetch_if #(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned INST_W = 32
);
  logic              flush;
  logic              pc_valid;
  logic [PC_W-1:0]   if_pc;
  logic              if_ready;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_exc;

  modport master (
    input  flush, pc_valid, if_pc, imem_ack, imem_rdata, id_ready,
    output if_ready, imem_req, imem_addr, id_valid, id_pc, id_inst, id_exc
  );

  modport slave (
    output flush, pc_valid, if_pc, imem_ack, imem_rdata, id_ready,
    input  if_ready, imem_req, imem_addr, id_valid, id_pc, id_inst, id_exc
  );
endinterface

// File: rtl/ysyx_22040931_ifu_fetch.sv
// Instruction fetch: single-outstanding imem read feeding a 2-entry FIFO to ID.
// Optional YSYX_22040931_INST_MISALIGN_CHECK_EN turns misaligned PCs into exception entries.
module ysyx_22040931_ifu_fetch #(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned INST_W = 32
) (
  input logic                    clock,
  input logic                    reset,
  ysyx_22040931_ifu_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic [PC_W-1:0]   addr_q;
  logic [PC_W-1:0]   pc_q   [2];
  logic [INST_W-1:0] inst_q [2];
  logic              exc_q  [2];

  logic              ack_wait;
  logic              misalign;
  logic [2:0]        occ;
  logic              room;
  logic              if_ready;
  logic              id_valid;
  logic              pop;
  logic              accept;
  logic              push_mem;
  logic              push;
  logic [1:0]        wr_pos;
  logic [PC_W-1:0]   push_pc;
  logic [INST_W-1:0] push_inst;
  logic              push_exc;

  always_comb begin
    ack_wait = (state_q == WAIT) & bus.imem_ack;
    id_valid = (count_q != 2'd0) & ~bus.flush;
    pop      = id_valid & bus.id_ready;
    // An outstanding kept request already owns a FIFO slot.
    occ      = {1'b0, count_q} + {2'b0, state_q == WAIT};
    room     = (occ - {2'b0, pop}) < 3'd2;
`ifdef YSYX_22040931_INST_MISALIGN_CHECK_EN
    misalign = |bus.if_pc[1:0];
    if_ready = ~bus.flush & room & ((state_q == IDLE) | (ack_wait & ~misalign));
`else
    misalign = 1'b0;
    if_ready = ~bus.flush & room & ((state_q == IDLE) | ack_wait);
`endif
    accept   = bus.pc_valid & if_ready;
    push_mem = ack_wait & ~bus.flush;
    push     = push_mem | (accept & misalign);
    wr_pos   = count_q - {1'b0, pop};
    if (push_mem) begin
      push_pc   = addr_q;
      push_inst = bus.imem_rdata;
      push_exc  = 1'b0;
    end else begin
      push_pc   = bus.if_pc;
      push_inst = INST_W'(32'h0000_0013);
      push_exc  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept & ~misalign) state_d = WAIT;
      WAIT: begin
        if (bus.imem_ack)    state_d = accept ? WAIT : IDLE;
        else if (bus.flush)  state_d = DRAIN;
      end
      DRAIN:   if (bus.imem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (bus.flush) count_d = '0;
    else           count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        exc_q[i]  <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) addr_q <= bus.if_pc;
      if (~bus.flush) begin
        if (pop) begin
          pc_q[0]   <= pc_q[1];
          inst_q[0] <= inst_q[1];
          exc_q[0]  <= exc_q[1];
        end
        // Later write wins, so a push into slot 0 overrides the shift above.
        if (push) begin
          pc_q[wr_pos[0]]   <= push_pc;
          inst_q[wr_pos[0]] <= push_inst;
          exc_q[wr_pos[0]]  <= push_exc;
        end
      end
    end
  end

  assign bus.if_ready  = if_ready;
  assign bus.imem_req  = (state_q == WAIT) | (state_q == DRAIN);
  assign bus.imem_addr = addr_q;
  assign bus.id_valid  = id_valid;
  assign bus.id_pc     = pc_q[0];
  assign bus.id_inst   = inst_q[0];
  assign bus.id_exc    = exc_q[0];

endmodule

// File: tb/tb_ysyx_22040931_ifu_fetch.sv
// Bench for ysyx_22040931_ifu_fetch: directed scenarios then random traffic,
// checked every cycle against a queue-based transaction model.
module tb_ysyx_22040931_ifu_fetch;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INST_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ysyx_22040931_ifu_fetch_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

  ysyx_22040931_ifu_fetch #(.PC_W(PC_W), .INST_W(INST_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        exc;
  } ent_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ent_t        q[$];
  bit          m_out;
  bit          m_drop;
  logic [63:0] m_addr;
  int unsigned m_lat;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out  = 1'b0;
    m_drop = 1'b0;
    m_addr = '0;
    m_lat  = 0;
  endtask

  task automatic idle_inputs();
    bus.pc_valid   = 1'b0;
    bus.if_pc      = '0;
    bus.id_ready   = 1'b0;
    bus.flush      = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(bit pcv, logic [63:0] pc, bit idr, bit fl, int unsigned lat);
    bit   ack, idv, pop, can, acc, mis;
    int   occ;
    ent_t e;
    ack = m_out && (m_lat == 0);
    bus.pc_valid   = pcv;
    bus.if_pc      = pc;
    bus.id_ready   = idr;
    bus.flush      = fl;
    bus.imem_ack   = ack;
    bus.imem_rdata = ack ? mem_word(m_addr) : 32'($urandom);
    #1;
`ifdef YSYX_22040931_INST_MISALIGN_CHECK_EN
    mis = (pc[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    idv = (q.size() != 0) && !fl;
    pop = idv && idr;
    occ = q.size() + ((m_out && !m_drop) ? 1 : 0);
    can = !fl && ((occ - (pop ? 1 : 0)) < 2) && (!m_out || (!m_drop && ack && !mis));
    check_eq("if_ready", bus.if_ready, can);
    check_eq("imem_req", bus.imem_req, m_out);
    check_eq("imem_addr", bus.imem_addr, m_addr);
    check_eq("id_valid", bus.id_valid, idv);
    if (idv) begin
      check_eq("id_pc", bus.id_pc, q[0].pc);
      check_eq("id_inst", bus.id_inst, q[0].inst);
      check_eq("id_exc", bus.id_exc, q[0].exc);
    end
    acc = pcv && can;
    if (m_out && !ack) m_lat--;
    if (fl) begin
      q.delete();
      if (m_out && ack) begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else if (m_out) begin
        m_drop = 1'b1;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (m_out && ack) begin
        if (!m_drop) begin
          e.pc = m_addr; e.inst = mem_word(m_addr); e.exc = 1'b0;
          q.push_back(e);
        end
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      if (acc && mis) begin
        e.pc = pc; e.inst = 32'h0000_0013; e.exc = 1'b1;
        q.push_back(e);
      end
    end
    if (acc) begin
      m_addr = pc;
      if (!mis) begin
        m_out  = 1'b1;
        m_drop = 1'b0;
        m_lat  = lat;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic settle(int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    bit          pcv, idr, fl;
    logic [63:0] pc;
    idle_inputs();
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_eq("rst_imem_req", bus.imem_req, 1'b0);
    check_eq("rst_imem_addr", bus.imem_addr, 64'h0);
    check_eq("rst_id_valid", bus.id_valid, 1'b0);
    check_eq("rst_id_pc", bus.id_pc, 64'h0);
    check_eq("rst_id_inst", bus.id_inst, 32'h0);
    check_eq("rst_id_exc", bus.id_exc, 1'b0);
    check_eq("rst_if_ready", bus.if_ready, 1'b1);

    // Single fetch, zero-wait ack
    step(1'b1, 64'h8000_0000, 1'b1, 1'b0, 0);
    step(1'b0, '0, 1'b1, 1'b0, 0);
    check_eq("first_pc", bus.id_pc, 64'h8000_0000);
    check_eq("first_inst", bus.id_inst, mem_word(64'h8000_0000));
    settle(2);

    // Back-to-back stream
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b1, 1'b0, 0);
    settle(3);

    // Stalled consumer fills the FIFO, then drains in order
    for (int unsigned i = 0; i < 5; i++) step(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0, 0);
    check_eq("full_if_ready", bus.if_ready, 1'b0);
    check_eq("full_head", bus.id_pc, 64'h8000_0000);
    settle(4);

    // Flush during a slow request: entry queued, request goes to DRAIN
    step(1'b1, 64'h8000_0040, 1'b0, 1'b0, 0);
    step(1'b0, '0, 1'b0, 1'b0, 0);
    step(1'b1, 64'h8000_0100, 1'b0, 1'b0, 3);
    step(1'b0, '0, 1'b0, 1'b0, 0);
    step(1'b1, 64'h8000_0200, 1'b1, 1'b1, 0);
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 64'h8000_0300, 1'b1, 1'b0, 0);
    settle(3);

    // Flush coinciding with ack and id_ready
    step(1'b1, 64'h8000_0400, 1'b0, 1'b0, 0);
    step(1'b1, 64'h8000_0404, 1'b0, 1'b0, 0);
    step(1'b0, '0, 1'b1, 1'b1, 0);
    settle(2);

`ifdef YSYX_22040931_INST_MISALIGN_CHECK_EN
    step(1'b1, 64'h8000_0002, 1'b1, 1'b0, 0);
    check_eq("mis_req", bus.imem_req, 1'b0);
    check_eq("mis_inst", bus.id_inst, 32'h0000_0013);
    check_eq("mis_exc", bus.id_exc, 1'b1);
    settle(2);
`endif

    // Reset while a request is outstanding
    step(1'b1, 64'h8000_0500, 1'b1, 1'b0, 3);
    step(1'b0, '0, 1'b1, 1'b0, 0);
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_imem_req", bus.imem_req, 1'b0);
    check_eq("midrst_if_ready", bus.if_ready, 1'b1);
    check_eq("midrst_id_valid", bus.id_valid, 1'b0);

    for (int unsigned i = 0; i < 3000; i++) begin
      pcv = ($urandom_range(0, 3) != 0);
      idr = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      pc  = 64'h8000_0000 + (64'($urandom_range(0, 1023)) << 2);
`ifdef YSYX_22040931_INST_MISALIGN_CHECK_EN
      if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
`endif
      step(pcv, pc, idr, fl, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
